// File: rtl/inst_cache_nway.sv
// Set-associative, read-only instruction cache between the fetch stage and
// an AXI read master. Misses refill a whole line with early restart on the
// requested word; uncached fetches go out as single-beat reads. An
// invalidate walker clears one set per cycle after reset and on inv_all.
//
// Handshakes: a request is accepted on a clock edge where s_arvalid and
// s_arready are both high; an AXI address is accepted on an edge where
// m_arvalid and m_arready are both high, and m_arvalid stays high until
// then; a read beat is consumed on every edge where m_rvalid is high
// (m_rready is tied high); s_rvalid is a one-cycle pulse with no back-pressure.
module inst_cache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic        flush,
  input  logic        inv_all,
  output logic        inv_busy,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    S_INV,
    S_IDLE,
    S_LOOKUP,
    S_MISS_AR,
    S_REFILL,
    S_UNC_AR,
    S_UNC_R
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  inv_cnt_q;
  logic [31:0]       addr_q;
  logic              drop_q;
  logic [WORD_W-1:0] beat_q;
  logic [WAY_W-1:0]  victim_q;
  logic              vic_rr_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;
  logic [WAY_W-1:0]  rr_q [SETS];

  // Storage: data and tag arrays read synchronously, valid bits as flops
  logic [31:0]       data_mem [WAYS][SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [31:0]       rd_word  [WAYS];
  logic [TAG_W-1:0]  rd_tag   [WAYS];
  logic [WAYS-1:0]   valid_q  [SETS];

  // Fields of the latched request address
  logic [TAG_W-1:0]  lat_tag;
  logic [IDX_W-1:0]  lat_idx;
  logic [WORD_W-1:0] lat_off;
  assign lat_tag = addr_q[31 -: TAG_W];
  assign lat_idx = addr_q[OFF_W +: IDX_W];
  assign lat_off = addr_q[2 +: WORD_W];

  // Arrays are addressed by the incoming fetch while idle so the lookup
  // cycle sees the line right after acceptance
  logic [IDX_W-1:0]  rd_idx;
  logic [WORD_W-1:0] rd_off;
  assign rd_idx = (state_q == S_IDLE) ? s_araddr[OFF_W +: IDX_W] : lat_idx;
  assign rd_off = (state_q == S_IDLE) ? s_araddr[2 +: WORD_W]    : lat_off;

  logic beat_we;
  logic line_done;
  assign beat_we   = (state_q == S_REFILL) && m_rvalid;
  assign line_done = beat_we && m_rlast;

  // Hit detection and victim choice for the latched set
  logic [WAYS-1:0]  hit_vec;
  logic [31:0]      hit_word;
  logic             have_inv;
  logic [WAY_W-1:0] first_inv;
  logic             hit;

  // Compare every way's tag; find the lowest invalid way
  always_comb begin
    hit_vec   = '0;
    hit_word  = '0;
    have_inv  = 1'b0;
    first_inv = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lat_idx][w] && (rd_tag[w] == lat_tag)) begin
        hit_vec[w] = 1'b1;
        hit_word   = hit_word | rd_word[w];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[lat_idx][w]) begin
        have_inv  = 1'b1;
        first_inv = WAY_W'(w);
      end
    end
  end
  assign hit = |hit_vec;

  logic [WAY_W-1:0] next_rr;
  assign next_rr = (rr_q[lat_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[lat_idx] + 1'b1;

  // Array write on refill beats and synchronous read of every way
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (beat_we && (victim_q == WAY_W'(w))) begin
        data_mem[w][{lat_idx, beat_q}] <= m_rdata;
      end
      if (line_done && (victim_q == WAY_W'(w))) begin
        tag_mem[w][lat_idx] <= lat_tag;
      end
      rd_word[w] <= data_mem[w][{rd_idx, rd_off}];
      rd_tag[w]  <= tag_mem[w][rd_idx];
    end
  end

  // Valid bits: cleared set by set during the walk, set when a line completes
  always_ff @(posedge clk) begin
    if (state_q == S_INV) begin
      valid_q[inv_cnt_q] <= '0;
    end else if (line_done) begin
      valid_q[lat_idx][victim_q] <= 1'b1;
    end
  end

  // Control FSM: walker, lookup, refill and uncached paths
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INV;
      inv_cnt_q  <= '0;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      beat_q     <= '0;
      victim_q   <= '0;
      vic_rr_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else begin
      case (state_q)
        S_INV: begin
          inv_cnt_q <= inv_cnt_q + 1'b1;
          if (inv_cnt_q == IDX_W'(SETS - 1)) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          drop_q <= 1'b0;
          if (inv_all) begin
            inv_cnt_q <= '0;
            state_q   <= S_INV;
          end else if (s_arvalid && s_arready) begin
            addr_q  <= s_araddr;
            state_q <= cache_ena ? S_LOOKUP : S_UNC_AR;
          end
        end
        S_LOOKUP: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
            state_q   <= S_IDLE;
          end else begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
            victim_q   <= have_inv ? first_inv : rr_q[lat_idx];
            vic_rr_q   <= !have_inv;
            beat_q     <= '0;
            state_q    <= S_MISS_AR;
          end
        end
        S_MISS_AR: begin
          drop_q <= drop_q | flush;
          if (m_arready) begin
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          drop_q <= drop_q | flush;
          if (m_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (m_rlast) begin
              if (vic_rr_q) begin
                rr_q[lat_idx] <= next_rr;
              end
              state_q <= S_IDLE;
            end
          end
        end
        S_UNC_AR: begin
          drop_q <= drop_q | flush;
          if (m_arready) begin
            state_q <= S_UNC_R;
          end
        end
        S_UNC_R: begin
          drop_q <= drop_q | flush;
          if (m_rvalid && m_rlast) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_INV;
      endcase
    end
  end

  // Response path: lookup hit, early-restart beat, or uncached beat
  logic lookup_rv;
  logic early_rv;
  logic unc_rv;
  assign lookup_rv = (state_q == S_LOOKUP) && hit;
  assign early_rv  = beat_we && (beat_q == lat_off);
  assign unc_rv    = (state_q == S_UNC_R) && m_rvalid && m_rlast;

  assign s_rvalid  = !rst && !drop_q && !flush && (lookup_rv || early_rv || unc_rv);
  assign s_rdata   = !s_rvalid ? 32'd0 : ((state_q == S_LOOKUP) ? hit_word : m_rdata);

  assign s_arready = !rst && (state_q == S_IDLE) && !flush && !inv_all;
  assign inv_busy  = rst || (state_q == S_INV);
  assign m_rready  = 1'b1;

  assign m_arvalid = !rst && ((state_q == S_MISS_AR) || (state_q == S_UNC_AR));
  assign m_araddr  = !m_arvalid ? 32'd0 :
                     (state_q == S_MISS_AR) ? {lat_tag, lat_idx, {OFF_W{1'b0}}} : addr_q;
  assign m_arlen   = (m_arvalid && (state_q == S_MISS_AR)) ? 8'(LINE_WORDS - 1) : 8'd0;

  assign hit_cnt   = rst ? 32'd0 : hit_cnt_q;
  assign miss_cnt  = rst ? 32'd0 : miss_cnt_q;

endmodule
